// File: rtl/vga_linedoubler_ce_if.sv
// Video bundle for the line doubler: half-rate source pixels in, doubled/bypassed pixels out.
interface vga_linedoubler_ce_if #(
  parameter int CW = 3
);
  logic          ce_in;
  logic [CW-1:0] ri, gi, bi;
  logic          hsync_in_n;
  logic          vsync_in_n;
  logic [CW-1:0] ro, go, bo;
  logic          hsync_n;
  logic          vsync_n;

  modport master (
    output ce_in, ri, gi, bi, hsync_in_n, vsync_in_n,
    input  ro, go, bo, hsync_n, vsync_n
  );

  modport slave (
    input  ce_in, ri, gi, bi, hsync_in_n, vsync_in_n,
    output ro, go, bo, hsync_n, vsync_n
  );
endinterface

// File: rtl/vga_linedoubler_ce.sv
// Single-clock scandoubler: captures each source line on ce_in into one of two line
// buffers and replays the previous line twice at the full clock rate.
module vga_linedoubler_ce #(
  parameter int CW         = 3,
  parameter int MAX_LINE   = 512,
  parameter int SCAN_SHIFT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_scandoubling,
  input  logic                 enable_scaneffect,
  vga_linedoubler_ce_if.slave  vid,
  output logic                 line_overflow
);
  localparam int             AW      = $clog2(MAX_LINE);
  localparam int             PW      = 3 * CW;
  localparam logic [AW-1:0]  LAST_WX = AW'(MAX_LINE - 1);
  localparam logic [AW-1:0]  CNT_MAX = '1;

  logic [PW-1:0] r_buf [0:(2 << AW) - 1];
  logic [PW-1:0] r_rd_data;

  logic [AW-1:0] r_wx, r_rx, r_line_len, r_hs_len, r_hs_cnt;
  logic          r_wsel, r_rsel, r_copy, r_hs_prev, r_vs_samp;
  logic          r_s1_hs_act, r_s1_vs, r_s1_copy, r_s1_blank;
  logic [PW-1:0] r_col;
  logic          r_hs_o, r_vs_o;

  logic [PW-1:0] w_pix;
  logic          w_hs_fall, w_hs_rise, w_wr_en, w_rx_last;
  logic [AW:0]   w_wr_addr;
  logic [PW-1:0] w_col;

  assign w_pix     = {vid.ri, vid.gi, vid.bi};
  assign w_hs_fall = vid.ce_in & r_hs_prev & ~vid.hsync_in_n;
  assign w_hs_rise = vid.ce_in & ~r_hs_prev & vid.hsync_in_n;
  // The first pixel of a new line lands at index 0 of the buffer we are swapping to.
  assign w_wr_en   = vid.ce_in & (w_hs_fall | (r_wx < LAST_WX));
  assign w_wr_addr = w_hs_fall ? {~r_wsel, {AW{1'b0}}} : {r_wsel, r_wx};
  assign w_rx_last = (r_rx == r_line_len - AW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wx          <= '0;
      r_wsel        <= 1'b0;
      r_rsel        <= 1'b0;
      r_line_len    <= '0;
      r_hs_len      <= '0;
      r_hs_cnt      <= '0;
      r_hs_prev     <= 1'b1;
      r_vs_samp     <= 1'b1;
      line_overflow <= 1'b0;
    end else if (vid.ce_in) begin
      r_hs_prev <= vid.hsync_in_n;
      r_vs_samp <= vid.vsync_in_n;
      if (w_hs_fall) begin
        r_line_len <= r_wx;
        r_rsel     <= r_wsel;
        r_wsel     <= ~r_wsel;
        r_wx       <= AW'(1);
      end else if (r_wx < LAST_WX) begin
        r_wx <= r_wx + AW'(1);
      end else begin
        line_overflow <= 1'b1;
      end
      if (!vid.hsync_in_n) begin
        if (w_hs_fall)                r_hs_cnt <= AW'(1);
        else if (r_hs_cnt != CNT_MAX) r_hs_cnt <= r_hs_cnt + AW'(1);
      end
      if (w_hs_rise) r_hs_len <= r_hs_cnt;
    end
  end

  // NOTE: the line buffers carry no reset; stale contents are never shown because
  // replay length comes from line_len, which is reset to zero (blank output).
  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[w_wr_addr] <= w_pix;
    r_rd_data <= r_buf[{r_rsel, r_rx}];
  end

  always_ff @(posedge clk) begin
    if (reset || w_hs_fall) begin
      r_rx   <= '0;
      r_copy <= 1'b0;
    end else if (w_rx_last) begin
      r_rx   <= '0;
      r_copy <= 1'b1;
    end else begin
      r_rx <= r_rx + AW'(1);
    end
  end

  // Sideband delayed by one stage to line up with the synchronous RAM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_hs_act <= 1'b0;
      r_s1_vs     <= 1'b1;
      r_s1_copy   <= 1'b0;
      r_s1_blank  <= 1'b1;
    end else begin
      r_s1_hs_act <= (r_rx < r_hs_len);
      r_s1_vs     <= r_vs_samp;
      r_s1_copy   <= r_copy;
      r_s1_blank  <= (r_line_len == '0);
    end
  end

  // NOTE: always_comb uses blocking assignments and gives w_col a default first,
  // so no branch can leave it unassigned and infer a latch.
  always_comb begin
    w_col = r_rd_data;
    if (r_s1_blank) begin
      w_col = '0;
    end else if (r_s1_copy && enable_scaneffect) begin
      for (int c = 0; c < 3; c++) w_col[c*CW +: CW] = r_rd_data[c*CW +: CW] >> SCAN_SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col  <= '0;
      r_hs_o <= 1'b1;
      r_vs_o <= 1'b1;
    end else if (!enable_scandoubling) begin
      if (vid.ce_in) begin
        r_col  <= w_pix;
        r_hs_o <= vid.hsync_in_n;
        r_vs_o <= vid.vsync_in_n;
      end
    end else begin
      r_col  <= w_col;
      r_hs_o <= ~r_s1_hs_act | r_s1_blank;
      r_vs_o <= r_s1_vs;
    end
  end

  assign vid.ro      = r_col[2*CW +: CW];
  assign vid.go      = r_col[CW +: CW];
  assign vid.bo      = r_col[0 +: CW];
  assign vid.hsync_n = r_hs_o;
  assign vid.vsync_n = r_vs_o;
endmodule
